// File: rtl/fetch_stage.sv
// Multicycle instruction-fetch stage: owns the PC, runs a req/ready handshake
// against instruction memory and presents one buffered instruction downstream.
module fetch_stage #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic [WIDTH-1:0] imem_rdata,
  input  logic             imem_ready,
  input  logic             StallF,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_target,
  output logic [WIDTH-1:0] inst,
  output logic [WIDTH-1:0] pc,
  output logic             fetch_valid
);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN, VALID} state_t;

  state_t           state;
  logic [WIDTH-1:0] pc_q, inst_buf, pc_buf, tgt_q, tgt;
  logic             req_q, vld_q;

  assign tgt = {redirect_target[WIDTH-1:2], 2'b00};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pc_q     <= RESET_PC;
      tgt_q    <= '0;
      inst_buf <= '0;
      pc_buf   <= '0;
      req_q    <= 1'b0;
      vld_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state <= REQ;
          req_q <= 1'b1;
          if (redirect) pc_q <= tgt;
        end
        REQ: begin
          if (imem_ready && !redirect) begin
            inst_buf <= imem_rdata;
            pc_buf   <= pc_q;
            pc_q     <= pc_q + WIDTH'(4);
            state    <= VALID;
            req_q    <= 1'b0;
            vld_q    <= 1'b1;
          end else if (imem_ready) begin
            pc_q <= tgt;
          end else if (redirect) begin
            // memory still owns this address; park the target until ready
            tgt_q <= tgt;
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (redirect) tgt_q <= tgt;
          if (imem_ready) begin
            pc_q  <= redirect ? tgt : tgt_q;
            state <= REQ;
          end
        end
        VALID: begin
          // redirect drops the buffered instruction even when stalled
          if (redirect) begin
            pc_q  <= tgt;
            state <= REQ;
            req_q <= 1'b1;
            vld_q <= 1'b0;
          end else if (!StallF) begin
            state <= REQ;
            req_q <= 1'b1;
            vld_q <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          req_q <= 1'b0;
          vld_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign fetch_valid = vld_q;
  assign inst        = vld_q ? inst_buf : '0;
  assign pc          = vld_q ? pc_buf   : '0;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus a randomized run checked by a
// program-order scoreboard and a latency-configurable memory model.
module tb_fetch_stage;

  logic        clk = 1'b0, rst = 1'b1;
  logic        imem_req, fetch_valid;
  logic [31:0] imem_addr, inst, pc;
  logic [31:0] imem_rdata = '0, redirect_target = '0;
  logic        imem_ready = 1'b0, StallF = 1'b0, redirect = 1'b0;

  logic        rst1 = 1'b1, req1, fv1;
  logic [31:0] addr1, inst1, pc1;
  logic [31:0] rdata1 = '0, tgt1 = '0;
  logic        ready1 = 1'b0, stall1 = 1'b0, redir1 = 1'b0;

  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  fetch_stage #(.WIDTH(32), .RESET_PC(32'h0000_0000)) u0 (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready), .StallF(StallF),
    .redirect(redirect), .redirect_target(redirect_target),
    .inst(inst), .pc(pc), .fetch_valid(fetch_valid));

  fetch_stage #(.WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) u1 (
    .clk(clk), .rst(rst1), .imem_req(req1), .imem_addr(addr1),
    .imem_rdata(rdata1), .imem_ready(ready1), .StallF(stall1),
    .redirect(redir1), .redirect_target(tgt1),
    .inst(inst1), .pc(pc1), .fetch_valid(fv1));

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    if (a == 32'h4) return 32'h0010_0113;
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: exp_pc is the next address in program order to be consumed.
  int          lat = 1, mcnt = 0, n_present = 0;
  logic        rand_lat = 1'b0;
  logic        outst = 1'b0, taint = 1'b0, got_resp = 1'b0, resp_drop = 1'b0;
  logic        prev_leave = 1'b0, prev_hold = 1'b0;
  logic [31:0] out_addr = '0, exp_pc = '0;

  task automatic step(input logic s, input logic r, input logic [31:0] t);
    logic        rdy, req_now;
    logic [31:0] addr_now;
    StallF = s; redirect = r; redirect_target = t;
    if (rand_lat && !outst && imem_req) lat = $urandom_range(1, 4);
    rdy = imem_req && (mcnt + 1 >= lat);
    imem_ready = rdy;
    imem_rdata = rdy ? memf(imem_addr) : $urandom;

    if (outst) begin
      chk("req_held", {31'b0, imem_req}, 32'd1);
      chk("addr_stable", imem_addr, out_addr);
    end else if (imem_req) begin
      chk("req_addr", imem_addr, exp_pc);
    end
    if (got_resp) chk("valid_after_ready", {31'b0, fetch_valid}, resp_drop ? 32'd0 : 32'd1);
    if (prev_leave) chk("valid_fall", {31'b0, fetch_valid}, 32'd0);
    if (prev_hold) chk("valid_hold", {31'b0, fetch_valid}, 32'd1);
    if (fetch_valid) begin
      chk("pres_pc", pc, exp_pc);
      chk("pres_inst", inst, memf(exp_pc));
      chk("no_req_in_valid", {31'b0, imem_req}, 32'd0);
      n_present++;
    end else begin
      chk("nop_inst", inst, 32'd0);
      chk("nop_pc", pc, 32'd0);
    end

    req_now = imem_req; addr_now = imem_addr;
    if (imem_req && r) taint = 1'b1;
    prev_leave = fetch_valid && (!s || r);
    prev_hold  = fetch_valid && s && !r;
    if (r) exp_pc = t & 32'hFFFF_FFFC;
    else if (fetch_valid && !s) exp_pc = exp_pc + 32'd4;

    @(posedge clk); #1;
    got_resp  = req_now && rdy;
    resp_drop = taint;
    outst     = req_now && !rdy;
    out_addr  = addr_now;
    if (!outst) taint = 1'b0;
    mcnt = outst ? mcnt + 1 : 0;
  endtask

  task automatic tick1();
    @(posedge clk); #1;
  endtask

  initial begin
    #2;
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_valid", {31'b0, fetch_valid}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // L=1 sequential fetch of two instructions
    lat = 1;
    step(0, 0, 0);
    chk("t1_req", {31'b0, imem_req}, 32'd1);
    chk("t1_addr0", imem_addr, 32'h0);
    step(0, 0, 0);
    chk("t1_v0", {31'b0, fetch_valid}, 32'd1);
    chk("t1_inst0", inst, 32'h0050_0093);
    chk("t1_pc0", pc, 32'h0);
    step(0, 0, 0);
    chk("t1_addr4", imem_addr, 32'h4);
    chk("t1_fall", {31'b0, fetch_valid}, 32'd0);
    step(0, 0, 0);
    chk("t1_inst1", inst, 32'h0010_0113);
    chk("t1_pc1", pc, 32'h4);
    step(0, 0, 0);

    // L=3, redirect in second request cycle at 0x8
    lat = 3;
    step(0, 0, 0);
    step(0, 1, 32'h100);
    chk("t3_req_held", {31'b0, imem_req}, 32'd1);
    chk("t3_addr_held", imem_addr, 32'h8);
    step(0, 0, 0);
    chk("t3_dropped", {31'b0, fetch_valid}, 32'd0);
    chk("t3_new_addr", imem_addr, 32'h100);

    // two redirects while draining: latest wins
    step(0, 1, 32'h200);
    step(0, 1, 32'h300);
    chk("t4_addr_held", imem_addr, 32'h100);
    step(0, 0, 0);
    chk("t4_new_addr", imem_addr, 32'h300);
    chk("t4_no_valid", {31'b0, fetch_valid}, 32'd0);

    // stall holds the presented instruction
    step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);
    chk("t2_valid", {31'b0, fetch_valid}, 32'd1);
    chk("t2_pc", pc, 32'h300);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0);
      chk("t2_hold_v", {31'b0, fetch_valid}, 32'd1);
      chk("t2_hold_pc", pc, 32'h300);
      chk("t2_hold_inst", inst, memf(32'h300));
      chk("t2_hold_noreq", {31'b0, imem_req}, 32'd0);
    end
    step(0, 0, 0);
    chk("t2_next_req", {31'b0, imem_req}, 32'd1);
    chk("t2_next_addr", imem_addr, 32'h304);

    // redirect beats stall in VALID
    step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);
    chk("t5_valid", {31'b0, fetch_valid}, 32'd1);
    step(1, 1, 32'h40);
    chk("t5_fall", {31'b0, fetch_valid}, 32'd0);
    chk("t5_addr", imem_addr, 32'h40);
    chk("t5_req", {31'b0, imem_req}, 32'd1);

    // randomized run against the scoreboard
    rand_lat = 1'b1;
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, $urandom);
    step(0, 0, 0);
    chk("rand_progress", {31'b0, n_present > 40}, 32'd1);

    // wrap, target alignment and reset during drain on the second instance
    chk("w_rst_addr", addr1, 32'hFFFF_FFFC);
    chk("w_rst_valid", {31'b0, fv1}, 32'd0);
    rst1 = 1'b0;
    tick1();
    chk("w_req", {31'b0, req1}, 32'd1);
    chk("w_addr", addr1, 32'hFFFF_FFFC);
    ready1 = 1'b1; rdata1 = 32'h0040_0013;
    tick1();
    ready1 = 1'b0;
    chk("w_valid", {31'b0, fv1}, 32'd1);
    chk("w_pc", pc1, 32'hFFFF_FFFC);
    chk("w_inst", inst1, 32'h0040_0013);
    tick1();
    chk("w_wrap", addr1, 32'h0);
    redir1 = 1'b1; tgt1 = 32'h103;
    tick1();
    redir1 = 1'b0;
    chk("w_drain_addr", addr1, 32'h0);
    ready1 = 1'b1;
    tick1();
    ready1 = 1'b0;
    chk("w_align", addr1, 32'h100);
    chk("w_no_valid", {31'b0, fv1}, 32'd0);
    redir1 = 1'b1; tgt1 = 32'h204;
    tick1();
    redir1 = 1'b0;
    chk("w_drain_req", {31'b0, req1}, 32'd1);
    #2 rst1 = 1'b1;
    #1;
    chk("w_rst_req2", {31'b0, req1}, 32'd0);
    chk("w_rst_addr2", addr1, 32'hFFFF_FFFC);
    chk("w_rst_valid2", {31'b0, fv1}, 32'd0);
    chk("w_rst_inst2", inst1, 32'h0);
    chk("w_rst_pc2", pc1, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
